// File: rtl/cpu_mc_pkg.sv
// rtl/cpu_mc_pkg.sv - opcodes, FSM states, flag indices and instruction fields for cpu_core_mc
package cpu_mc_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_ADDI  = 4'h6;
    localparam logic [3:0] OP_LDI   = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_JC    = 4'hC;
    localparam logic [3:0] OP_JN    = 4'hD;
    localparam logic [3:0] OP_CMP   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_EXECUTE = 2'd1;
    localparam logic [1:0] ST_MEM     = 2'd2;
    localparam logic [1:0] ST_HALTED  = 2'd3;

    // flags_out is packed {Z,C,N,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/cpu_mc_alu.sv
// rtl/cpu_mc_alu.sv - combinational ALU producing a result and {Z,C,N,V}
module cpu_mc_alu
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic            carry;
    logic            ovf;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // diff[DATA_W] is the borrow: set exactly when a < b unsigned
    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
                ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
                ovf    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

    assign flags = {result == '0, carry, result[MSB], ovf};

endmodule

// File: rtl/cpu_core_mc.sv
// rtl/cpu_core_mc.sv - multi-cycle CPU core with handshaked instruction and data memories
module cpu_core_mc
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              halt,
    output logic [ADDR_W-1:0] pc_out,
    output logic [3:0]        flags_out,
    output logic [CNT_W-1:0]  instr_count,
    input  logic [2:0]        dbg_reg_addr,
    output logic [DATA_W-1:0] dbg_reg_data
);

    localparam logic [3:0] REG_LIMIT = 4'(NUM_REGS);

    function automatic logic reg_ok(input logic [2:0] idx);
        return {1'b0, idx} < REG_LIMIT;
    endfunction

    logic [1:0]        state;
    logic [15:0]       ir;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        flags;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] rf [8];

    logic [3:0]        op;
    logic [2:0]        rd, rs1, rs2;
    logic [7:0]        imm8;
    logic [DATA_W-1:0] rd_val, rs1_val, rs2_val, imm_d;
    logic [DATA_W-1:0] alu_a, alu_b, alu_res, wr_data;
    logic [3:0]        alu_flags;
    logic              wr_en, take_jump, sets_flags;

    assign op   = ir[OP_HI:OP_LO];
    assign rd   = ir[RD_HI:RD_LO];
    assign rs1  = ir[RS1_HI:RS1_LO];
    assign rs2  = ir[RS2_HI:RS2_LO];
    assign imm8 = ir[IMM_HI:IMM_LO];

    assign imm_d   = DATA_W'(imm8);
    assign rd_val  = reg_ok(rd)  ? rf[rd]  : '0;
    assign rs1_val = reg_ok(rs1) ? rf[rs1] : '0;
    assign rs2_val = reg_ok(rs2) ? rf[rs2] : '0;

    assign alu_a = (op == OP_ADDI) ? rd_val : rs1_val;
    assign alu_b = (op == OP_ADDI) ? imm_d  : rs2_val;

    cpu_mc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_res),
        .flags  (alu_flags)
    );

    assign sets_flags = ((op >= OP_ADD) && (op <= OP_ADDI)) || (op == OP_CMP);

    always_comb begin
        take_jump = 1'b0;
        case (op)
            OP_JMP:  take_jump = 1'b1;
            OP_JZ:   take_jump = flags[FLAG_Z];
            OP_JC:   take_jump = flags[FLAG_C];
            OP_JN:   take_jump = flags[FLAG_N];
            default: take_jump = 1'b0;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = alu_res;
        if (state == ST_EXECUTE) begin
            if ((op >= OP_ADD) && (op <= OP_ADDI)) begin
                wr_en = 1'b1;
            end else if (op == OP_LDI) begin
                wr_en   = 1'b1;
                wr_data = imm_d;
            end
        end else if ((state == ST_MEM) && dmem_ack && (op == OP_LOAD)) begin
            wr_en   = 1'b1;
            wr_data = dmem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (wr_en && reg_ok(rd)) begin
            rf[rd] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
            ir    <= '0;
            pc    <= '0;
            flags <= '0;
            count <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if ((op == OP_LOAD) || (op == OP_STORE)) begin
                        state <= ST_MEM;
                    end else if (op == OP_HALT) begin
                        count <= count + CNT_W'(1);
                        state <= ST_HALTED;
                    end else begin
                        pc    <= take_jump ? ADDR_W'(imm8) : pc + ADDR_W'(1);
                        if (sets_flags) flags <= alu_flags;
                        count <= count + CNT_W'(1);
                        state <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        pc    <= pc + ADDR_W'(1);
                        count <= count + CNT_W'(1);
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_HALTED;
            endcase
        end
    end

    // reset parks the FSM in FETCH, so the request is masked to drop with rst itself
    assign imem_req     = (state == ST_FETCH) && !rst;
    assign imem_addr    = pc;
    assign dmem_req     = (state == ST_MEM);
    assign dmem_we      = dmem_req && (op == OP_STORE);
    assign dmem_addr    = dmem_req ? ADDR_W'(imm8) : '0;
    assign dmem_wdata   = dmem_req ? rd_val : '0;
    assign halt         = (state == ST_HALTED);
    assign pc_out       = pc;
    assign flags_out    = flags;
    assign instr_count  = count;
    assign dbg_reg_data = reg_ok(dbg_reg_addr) ? rf[dbg_reg_addr] : '0;

endmodule

// File: tb/tb_cpu_core_mc.sv
// tb/tb_cpu_core_mc.sv - scoreboard bench for cpu_core_mc against an ISA-level reference model
module tb_cpu_core_mc;
    import cpu_mc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halt;
    logic [7:0]  imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc_out, dbg_reg_data;
    logic [15:0] imem_rdata, instr_count;
    logic [3:0]  flags_out;
    logic [2:0]  dbg_reg_addr;

    cpu_core_mc dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .halt(halt), .pc_out(pc_out), .flags_out(flags_out), .instr_count(instr_count),
        .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data)
    );

    logic        rst_w = 1'b1;
    logic        imem_req_w, imem_ack_w, dmem_req_w, dmem_we_w, dmem_ack_w, halt_w;
    logic [9:0]  imem_addr_w, dmem_addr_w, pc_out_w;
    logic [15:0] imem_rdata_w, dmem_wdata_w, dmem_rdata_w, instr_count_w, dbg_reg_data_w;
    logic [3:0]  flags_out_w;
    logic [2:0]  dbg_reg_addr_w;

    cpu_core_mc #(.DATA_W(16), .ADDR_W(10), .NUM_REGS(4), .CNT_W(16)) dut_w (
        .clk(clk), .rst(rst_w),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
        .dmem_req(dmem_req_w), .dmem_we(dmem_we_w), .dmem_addr(dmem_addr_w), .dmem_wdata(dmem_wdata_w),
        .dmem_ack(dmem_ack_w), .dmem_rdata(dmem_rdata_w),
        .halt(halt_w), .pc_out(pc_out_w), .flags_out(flags_out_w), .instr_count(instr_count_w),
        .dbg_reg_addr(dbg_reg_addr_w), .dbg_reg_data(dbg_reg_data_w)
    );

    typedef struct { logic [7:0] pc; logic [3:0] flags; logic halt; logic [63:0] regs; int lat; } ret_t;
    typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; } acc_t;

    ret_t        ret_q[$];
    acc_t        acc_q[$];
    int          iwait_q[$];
    int          dwait_q[$];
    logic [15:0] imem [256];
    logic [7:0]  dmem [256];
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, halt_cyc = 0, stall_after = -1;
    bit          done_w = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ins_i(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction

    function automatic logic [15:0] ins_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] s1, input logic [2:0] s2);
        return {op, rd, s1, s2, 3'b000};
    endfunction

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic void alu_model(input int op, input int a, input int b,
                                      output int res, output logic [3:0] fl);
        int full, s;
        bit c, v;
        c = 0; v = 0; s = 0;
        case (op)
            1, 6:    begin full = a + b; c = (full > 255); s = sx(a) + sx(b); end
            2, 14:   begin full = a - b; c = (a < b);      s = sx(a) - sx(b); end
            3:       full = a & b;
            4:       full = a | b;
            default: full = a ^ b;
        endcase
        if (op == 1 || op == 2 || op == 6 || op == 14) v = (s > 127) || (s < -128);
        res = full & 255;
        fl  = {res == 0, c, res > 127, v};
    endfunction

    // Runs the loaded program at instruction level and queues everything the DUT should show
    task automatic run_model(input int max_steps, input int iw_max, input int dw_lo, input int dw_hi,
                             output bit halted);
        int regs[8];
        logic [7:0] mdmem [256];
        logic [3:0] fl;
        logic [15:0] ins;
        int pc, nxt, op, rd, s1, s2, imm, iw, dw, res, steps;
        ret_t e;
        acc_t a;
        for (int i = 0; i < 8; i++) regs[i] = 0;
        for (int i = 0; i < 256; i++) mdmem[i] = dmem[i];
        fl = 0; pc = 0; steps = 0; halted = 0;
        while (!halted && steps < max_steps) begin
            ins = imem[pc];
            op = int'(ins[15:12]); rd = int'(ins[11:9]); s1 = int'(ins[8:6]);
            s2 = int'(ins[5:3]);   imm = int'(ins[7:0]);
            iw = $urandom_range(0, iw_max);
            iwait_q.push_back(iw);
            e.lat = 2 + iw;
            nxt = (pc + 1) % 256;
            case (op)
                1, 2, 3, 4, 5, 6, 14: begin
                    alu_model(op, (op == 6) ? regs[rd] : regs[s1], (op == 6) ? imm : regs[s2], res, fl);
                    if (op != 14) regs[rd] = res;
                end
                7: regs[rd] = imm;
                8, 9: begin
                    dw = $urandom_range(dw_lo, dw_hi);
                    dwait_q.push_back(dw);
                    e.lat += 1 + dw;
                    a.we = (op == 9); a.addr = 8'(imm); a.wdata = (op == 9) ? 8'(regs[rd]) : 8'h00;
                    acc_q.push_back(a);
                    if (op == 9) mdmem[imm] = 8'(regs[rd]);
                    else         regs[rd] = int'(mdmem[imm]);
                end
                10: nxt = imm;
                11: if (fl[3]) nxt = imm;
                12: if (fl[2]) nxt = imm;
                13: if (fl[1]) nxt = imm;
                15: begin halted = 1; nxt = pc; end
                default: ;
            endcase
            pc = nxt;
            e.pc = 8'(pc); e.flags = fl; e.halt = halted;
            for (int i = 0; i < 8; i++) e.regs[i*8 +: 8] = 8'(regs[i]);
            ret_q.push_back(e);
            steps++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic run_prog(input string name, input int max_steps, input int iw_max,
                            input int dw_lo, input int dw_hi);
        bit exp_halt;
        int t;
        ret_q.delete(); acc_q.delete(); iwait_q.delete(); dwait_q.delete();
        run_model(max_steps, iw_max, dw_lo, dw_hi, exp_halt);
        do_reset();
        t = 0;
        while (ret_q.size() > 0 && t < 3000) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        check({name, "_drained"}, 128'(ret_q.size()), 128'(0));
        check({name, "_accesses"}, 128'(acc_q.size()), 128'(0));
        if (exp_halt) check({name, "_halt"}, 128'(halt), 128'(1));
    endtask

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    initial begin : monitor
        int last_cnt, last_cyc;
        logic [63:0] regs;
        ret_t e;
        last_cnt = 0; last_cyc = 0; dbg_reg_addr = 3'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_cnt = 0; last_cyc = 0;
            end else if (int'(instr_count) != last_cnt) begin
                for (int r = 0; r < 8; r++) begin
                    dbg_reg_addr = 3'(r);
                    #1 regs[r*8 +: 8] = dbg_reg_data;
                end
                if (ret_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_retire: instr_count %0d with no expectation queued", instr_count);
                end else begin
                    e = ret_q.pop_front();
                    check("retire_state", {pc_out, flags_out, halt, regs}, {e.pc, e.flags, e.halt, e.regs});
                    check("retire_latency", 128'(cyc - last_cyc), 128'(e.lat));
                    if (e.halt) halt_cyc = cyc;
                end
                last_cnt = int'(instr_count); last_cyc = cyc;
            end
        end
    end

    initial begin : imem_resp
        int left;
        bit busy;
        left = 0; busy = 0; imem_ack = 1'b0; imem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (rst) begin
                busy = 0;
            end else if (imem_req) begin
                if (!busy) begin
                    busy = 1;
                    left = (iwait_q.size() > 0) ? iwait_q.pop_front() : 0;
                end
                if (left == 0 && stall_after != 0) begin
                    imem_ack = 1'b1; imem_rdata = imem[imem_addr]; busy = 0;
                    if (stall_after > 0) stall_after--;
                end else if (left > 0) begin
                    left--;
                end
            end else begin
                imem_ack = ($urandom_range(0, 3) == 0);
                imem_rdata = 16'($urandom);
            end
        end
    end

    initial begin : dmem_resp
        int left;
        bit busy;
        acc_t a;
        left = 0; busy = 0; dmem_ack = 1'b0; dmem_rdata = 8'h0;
        forever begin
            @(negedge clk);
            dmem_ack = 1'b0;
            if (rst) begin
                busy = 0;
            end else if (dmem_req) begin
                if (!busy) begin
                    busy = 1;
                    left = (dwait_q.size() > 0) ? dwait_q.pop_front() : 0;
                    if (acc_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_dmem_access: addr %h we %b", dmem_addr, dmem_we);
                    end else begin
                        a = acc_q.pop_front();
                        check("dmem_access", {dmem_we, dmem_addr, (dmem_we ? dmem_wdata : 8'h00)},
                              {a.we, a.addr, a.wdata});
                    end
                end
                if (left == 0) begin
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    dmem_ack = 1'b1; dmem_rdata = dmem[dmem_addr]; busy = 0;
                end else begin
                    left--;
                end
            end else begin
                dmem_ack = ($urandom_range(0, 3) == 0);
                dmem_rdata = 8'($urandom);
            end
        end
    end

    function automatic logic [15:0] prog_w(input logic [9:0] addr);
        if (addr == 10'd0)                    return ins_i(OP_LDI, 3'd1, 8'h80);
        if (addr >= 10'd1 && addr <= 10'd8)   return ins_r(OP_ADD, 3'd1, 3'd1, 3'd1);
        if (addr == 10'd9)                    return ins_r(OP_ADD, 3'd2, 3'd1, 3'd1);
        if (addr == 10'd10)                   return ins_i(OP_LDI, 3'd6, 8'h55);
        if (addr == 10'd11)                   return ins_r(OP_ADD, 3'd3, 3'd6, 3'd1);
        return ins_r(OP_NOP, 3'd0, 3'd0, 3'd0);
    endfunction

    initial begin : wide_resp
        imem_ack_w = 1'b0; imem_rdata_w = 16'h0; dmem_ack_w = 1'b0; dmem_rdata_w = 16'h0;
        forever begin
            @(negedge clk);
            imem_ack_w = imem_req_w;
            imem_rdata_w = prog_w(imem_addr_w);
        end
    end

    task automatic wait_count_w(input int n);
        int t;
        t = 0;
        while (int'(instr_count_w) != n && t < 3000) begin @(negedge clk); t++; end
    endtask

    initial begin : wide_check
        dbg_reg_addr_w = 3'd0;
        repeat (2) @(posedge clk);
        #2 rst_w = 1'b0;
        wait_count_w(10);
        check("wide_add_flags", {instr_count_w, flags_out_w}, {16'd10, 4'b1101});
        dbg_reg_addr_w = 3'd2; #1 check("wide_add_r2", 128'(dbg_reg_data_w), 128'(16'h0000));
        dbg_reg_addr_w = 3'd1; #1 check("wide_r1", 128'(dbg_reg_data_w), 128'(16'h8000));
        wait_count_w(12);
        dbg_reg_addr_w = 3'd3; #1 check("wide_dropped_src", 128'(dbg_reg_data_w), 128'(16'h8000));
        dbg_reg_addr_w = 3'd6; #1 check("wide_oob_read", 128'(dbg_reg_data_w), 128'(16'h0000));
        wait_count_w(1023);
        check("wide_pc_top", {instr_count_w, pc_out_w}, {16'd1023, 10'h3FF});
        wait_count_w(1024);
        check("wide_pc_wrap", {instr_count_w, pc_out_w}, {16'd1024, 10'h000});
        done_w = 1'b1;
    end

    initial begin : main
        int t, len;
        for (int i = 0; i < 256; i++) begin imem[i] = 16'hF000; dmem[i] = 8'($urandom); end
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, halt, pc_out, flags_out, instr_count},
              {1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 4'h0, 16'h0000});

        imem[0] = ins_i(OP_LDI, 3'd1, 8'd5);
        imem[1] = ins_i(OP_LDI, 3'd2, 8'd3);
        imem[2] = ins_r(OP_ADD, 3'd3, 3'd1, 3'd2);
        imem[3] = 16'hF000;
        run_prog("t_add", 20, 0, 0, 0);
        check("t_add_total_cycles", 128'(halt_cyc), 128'(8));

        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
        imem[0] = ins_i(OP_LDI, 3'd1, 8'hFF);
        imem[1] = ins_i(OP_ADDI, 3'd1, 8'h01);
        imem[2] = ins_i(OP_JZ, 3'd0, 8'h20);
        run_prog("t_carry", 20, 2, 0, 0);
        check("t_carry_pc", 128'(pc_out), 128'(8'h20));

        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
        imem[0]    = ins_i(OP_LDI, 3'd1, 8'd3);
        imem[1]    = ins_i(OP_LDI, 3'd2, 8'd5);
        imem[2]    = ins_r(OP_CMP, 3'd0, 3'd1, 3'd2);
        imem[3]    = ins_i(OP_JC, 3'd0, 8'h10);
        imem[8'h10] = ins_i(OP_JN, 3'd0, 8'h20);
        imem[8'h20] = ins_i(OP_JZ, 3'd0, 8'h30);
        run_prog("t_cmp", 20, 1, 0, 0);
        check("t_cmp_pc", 128'(pc_out), 128'(8'h21));

        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
        imem[0] = ins_i(OP_LDI, 3'd4, 8'hA5);
        imem[1] = ins_i(OP_STORE, 3'd4, 8'h10);
        imem[2] = ins_i(OP_LOAD, 3'd5, 8'h10);
        run_prog("t_mem", 20, 0, 2, 2);

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 256; i++) begin imem[i] = 16'hF000; dmem[i] = 8'($urandom); end
            len = $urandom_range(12, 30);
            for (int p = 0; p < len; p++) begin
                imem[p] = 16'($urandom);
                imem[p][15:12] = 4'($urandom_range(0, 14));
                if (imem[p][15:12] >= OP_JMP && imem[p][15:12] <= OP_JN)
                    imem[p][7:0] = 8'($urandom_range(p + 1, len));
            end
            run_prog("t_rand", 100, 3, 0, 3);
        end

        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
        imem[0] = ins_i(OP_LDI, 3'd1, 8'd5);
        imem[1] = ins_i(OP_LDI, 3'd2, 8'd3);
        stall_after = 2;
        run_prog("t_stall", 2, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_hold", {imem_req, imem_addr, pc_out, instr_count}, {1'b1, 8'd2, 8'd2, 16'd2});
        end
        @(posedge clk);
        #5 rst = 1'b1;
        #1 check("stall_async_reset", {imem_req, pc_out, instr_count, flags_out}, {1'b0, 8'd0, 16'd0, 4'd0});
        @(negedge clk);
        stall_after = -1;

        t = 0;
        while (!done_w && t < 4000) begin @(negedge clk); t++; end
        if (!done_w) begin
            n_cmp++; n_bad++;
            $display("FAIL wide_timeout: instr_count_w %0d never reached 1024", instr_count_w);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_core_mc.md
Name: cpu_core_mc

Overview:
Parametrised multi-cycle successor to the single-cycle 8-bit CPU top. It keeps the 16-bit instruction format and the 8-entry register file, and generalises the data width and PC width. The major change: instruction and data memories are external, reached through req/ack handshake ports that tolerate wait states. Architectural flags live in a register, and retired instructions are counted. It sits at the top of the processor, between the memory subsystem and the debug/test harness.

Parameters:
DATA_W, 8, datapath and register width; must be >= 8.
ADDR_W, 8, PC and memory address width; must be >= 8.
NUM_REGS, 8, register count; must be 2..8, since the encoding uses 3-bit register fields.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
imem_req  out  1  fetch request, held until ack
imem_addr  out  ADDR_W  fetch address (= PC)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  16  instruction word
dmem_req  out  1  data access request, held until ack
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  ADDR_W  data address
dmem_wdata  out  DATA_W  store data
dmem_ack  in  1  data access complete; dmem_rdata valid on load
dmem_rdata  in  DATA_W  load data
halt  out  1  core halted
pc_out  out  ADDR_W  current PC
flags_out  out  4  {Z,C,N,V}
instr_count  out  CNT_W  retired instructions
dbg_reg_addr  in  3  debug register select
dbg_reg_data  out  DATA_W  combinational read of the selected register; reads 0 if the index >= NUM_REGS

Behaviour:
- Reset values: PC=0, all registers=0, flags=0, instr_count=0, state=FETCH, halt=0, all req/we outputs=0, addr/wdata outputs=0. One clock, one reset domain.
- Encoding: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm8=[7:0].
  - imm8 is zero-extended to DATA_W.
  - Jump target = imm8 zero-extended to ADDR_W.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd = rs1 op rs2.
  - 6 ADDI: rd = rd + imm.
  - 7 LDI: rd = imm.
  - 8 LOAD: rd = mem[imm].
  - 9 STORE: mem[imm] = rd.
  - A JMP, B JZ, C JC, D JN: jump to imm8 (unconditional, or if Z / C / N set).
  - E CMP: flags from rs1 - rs2; no register write.
  - F HALT.
- Register fields >= NUM_REGS: writes are dropped and reads return 0.
- Flags:
  - Updated only by ops 1-6 and E. All other ops preserve them.
  - Z: result == 0. N: result MSB.
  - ADD/ADDI: C = carry-out, V = signed overflow.
  - SUB/CMP: C = borrow (1 iff rs1 < rs2 unsigned), V = signed overflow.
  - AND/OR/XOR: C = 0, V = 0.
  - A conditional jump tests the flag register as it stands before that instruction.
- States: FETCH, EXECUTE, MEM, HALTED.
- FETCH:
  - imem_req=1 and imem_addr=PC.
  - On a clock edge with imem_ack=1: latch imem_rdata into IR, deassert req next cycle, go to EXECUTE.
  - Otherwise stay; wait states are unbounded.
- EXECUTE (registers read combinationally):
  - ALU, LDI, CMP, NOP, and jumps: commit, PC = target or PC+1, instr_count+1, go to FETCH.
  - LOAD/STORE: go to MEM.
  - HALT: PC is not incremented, instr_count+1, go to HALTED.
- MEM:
  - dmem_req=1, dmem_we = (op==9), dmem_addr=imm, dmem_wdata=rd.
  - On ack: a LOAD writes dmem_rdata to rd. Then PC+1, instr_count+1, go to FETCH.
- Latency with zero-wait memory (ack seen on the first request cycle): 2 cycles per instruction, 3 for LOAD/STORE. Each wait-state cycle adds exactly one cycle.
- HALTED: halt=1, no requests issued, state frozen; exit only via rst.
- Wrap rules: PC wraps modulo 2^ADDR_W; instr_count wraps modulo 2^CNT_W; arithmetic is modulo 2^DATA_W.
- An ack received while the corresponding req is low is ignored.
- rst asserted mid-transaction: req drops immediately (asynchronous), the request is abandoned, and the memory side must tolerate this.

Decomposition:
- Package cpu_mc_pkg holds:
  - the opcode localparams (OP_NOP..OP_HALT);
  - the state encoding;
  - the flag bit indices;
  - the instruction field-position constants.
- One sub-module, cpu_mc_alu: combinational, DATA_W-parametrised, producing the result and {Z,C,N,V}.
- Register file and FSM are inline in cpu_core_mc.

Test Plan:
- LDI R1,5; LDI R2,3; ADD R3,R1,R2; HALT, with zero-wait memory -> R3=8, Z=0, halt=1, instr_count=4, total cycles = 8.
- LDI R1,0xFF; ADDI R1,1 -> R1=0x00, Z=1, C=1, V=0; then JZ 0x20 -> pc_out=0x20.
- CMP R1,R2 with R1=3, R2=5 -> C=1, N=1, Z=0, R-file unchanged; JC taken, JN taken, JZ not taken (PC+1).
- STORE R4 (0xA5) to 0x10, then LOAD R5 from 0x10, with dmem_ack delayed 3 cycles -> dmem_we=1 then 0, dmem_req held 3 cycles each, R5=0xA5, each instruction takes 5 cycles.
- imem_ack held low for 10 cycles -> state stays FETCH, imem_req=1 and PC unchanged throughout; rst pulsed mid-wait -> imem_req=0 in the same cycle, PC=0, instr_count=0.
- DATA_W=16, ADDR_W=10 build: PC at 0x3FF executing NOP -> PC wraps to 0x000; ADD 0x8000+0x8000 -> result 0, C=1, V=1.
